// File: rtl/term_in_fifo_pkg.sv
// -----------------------------------------------------------------------------
// term_in_fifo_pkg
// Shared router definitions used by the terminal-input FIFO:
//   DST_MSB / DST_LSB : position of the destination field inside a packet
//   dst_t             : destination field type
//   n_terms()         : number of terminals on a ROWS x COLUMS mesh
//                       (one terminal per edge port: 2*ROWS + 2*COLUMS)
// -----------------------------------------------------------------------------
package term_in_fifo_pkg;

   localparam int DST_MSB = 39;
   localparam int DST_LSB = 32;

   typedef logic [DST_MSB-DST_LSB:0] dst_t;

   function automatic int n_terms(input int rows, input int cols);
      return 2 * rows + 2 * cols;
   endfunction

endpackage

// File: rtl/term_fifo_ram.sv
// -----------------------------------------------------------------------------
// term_fifo_ram
// DEPTH x PCK_SZ storage with one synchronous write port and one
// asynchronous read port. Asynchronous read is what lets the FIFO present
// its head entry in the same cycle the read pointer moves.
// Ports:
//   clk     : clock, writes on rising edge
//   we      : write enable
//   waddr   : write address
//   wdata   : write data
//   raddr   : read address
//   rdata   : read data (combinational from raddr)
// -----------------------------------------------------------------------------
module term_fifo_ram #(
   parameter int DEPTH  = 16,
   parameter int PCK_SZ = 40,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [PCK_SZ-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [PCK_SZ-1:0] rdata
);

   logic [PCK_SZ-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/term_in_fifo.sv
// -----------------------------------------------------------------------------
// term_in_fifo
// First-word-fall-through FIFO between a mesh terminal and its router.
// Ports:
//   clk           : clock, all state on rising edge
//   reset         : asynchronous active-low reset
//   push          : terminal writes data_in this cycle
//   data_in       : packet from terminal
//   popin         : router consumes the head packet
//   data_out_i_in : head packet (zero while empty)
//   pndng_i_in    : FIFO non-empty (from registered count only)
//   full          : count == DEPTH
//   count         : occupancy
//   overflow      : one-cycle pulse after a dropped push
//   drop_cnt      : saturating count of dropped pushes
//   err_pop       : one-cycle pulse after a popin while empty
// Build option:
//   TERM_IN_FIFO_DST_CHECK_EN : when defined, pushes whose destination field
//   is not a valid terminal index are dropped like an overflow.
// -----------------------------------------------------------------------------
module term_in_fifo
   import term_in_fifo_pkg::*;
#(
   parameter int ROWS   = 4,
   parameter int COLUMS = 4,
   parameter int PCK_SZ = 40,
   parameter int DEPTH  = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [PCK_SZ-1:0]          data_in,
   input  logic                       popin,
   output logic [PCK_SZ-1:0]          data_out_i_in,
   output logic                       pndng_i_in,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   output logic [15:0]                drop_cnt,
   output logic                       err_pop
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [AW-1:0]     wr_ptr_reg;
   logic [AW-1:0]     rd_ptr_reg;
   logic [CW-1:0]     count_reg;
   logic              overflow_reg;
   logic              err_pop_reg;
   logic [15:0]       drop_cnt_reg;
   logic [PCK_SZ-1:0] ram_rdata;

   logic empty;
   logic is_full;
   logic dst_ok;
   logic do_push;
   logic do_pop;
   logic drop;

   assign empty   = (count_reg == '0);
   assign is_full = (count_reg == DEPTH_C);

`ifdef TERM_IN_FIFO_DST_CHECK_EN
   dst_t dst_field;
   assign dst_field = data_in[DST_MSB:DST_LSB];
   assign dst_ok    = (int'(dst_field) < n_terms(ROWS, COLUMS));
`else
   assign dst_ok    = 1'b1;
`endif

   // A pop from a full FIFO frees the slot the simultaneous push needs.
   assign do_pop  = popin & ~empty;
   assign do_push = push & dst_ok & (~is_full | do_pop);
   assign drop    = push & ~do_push;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
         err_pop_reg  <= 1'b0;
         drop_cnt_reg <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         count_reg    <= count_reg + CW'(do_push) - CW'(do_pop);
         overflow_reg <= drop;
         err_pop_reg  <= popin & empty;
         if (drop && (drop_cnt_reg != 16'hFFFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 16'd1;
         end
      end
   end

   term_fifo_ram #(
      .DEPTH  (DEPTH),
      .PCK_SZ (PCK_SZ),
      .AW     (AW)
   ) u_ram (
      .clk   (clk),
      .we    (do_push),
      .waddr (wr_ptr_reg),
      .wdata (data_in),
      .raddr (rd_ptr_reg),
      .rdata (ram_rdata)
   );

   // Gate the head with the registered non-empty flag so the output is zero
   // during and after reset instead of showing stale RAM contents.
   assign pndng_i_in    = ~empty;
   assign data_out_i_in = empty ? '0 : ram_rdata;
   assign full          = is_full;
   assign count         = count_reg;
   assign overflow      = overflow_reg;
   assign err_pop       = err_pop_reg;
   assign drop_cnt      = drop_cnt_reg;

endmodule
